tinyqv_mem_sequencer: RTL and testbench
=======================================

Name: tinyqv_mem_sequencer

Overview:
- Issues the memory beats for one decoded load or store.
- Covers plain single-word accesses and the TinyQV multi-register forms:
  - 2 or 4 consecutive-register load/store,
  - LCXT/SCXT, up to 8 registers,
  - fast memset, the same register stored repeatedly.
- Sits between the decoder/address adder and the memory controller.
- Sequences address, register index and beat count; only one access is outstanding at a time.

Parameters:
REG_ADDR_BITS, 4, width of register indices (matches the decoder)
ADDR_BITS, 28, width of memory byte address

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
start  input  1  request to begin a sequence; accepted only when start_ready=1
start_ready  output  1  high when in IDLE (combinational from state)
start_is_store  input  1  1=store, 0=load
start_addr  input  ADDR_BITS  byte address of first beat (rs1+imm)
start_reg  input  REG_ADDR_BITS  first register (rd for load, rs2 for store)
start_count  input  3  additional_mem_ops; beats = start_count+1
start_inc_reg  input  1  mem_op_increment_reg
start_mem_op  input  3  mem_op from decoder
mem_req_valid  output  1  memory request pending
mem_req_ready  input  1  memory accepts request this cycle
mem_req_write  output  1  request is a store
mem_req_addr  output  ADDR_BITS  address of current beat
mem_req_op  output  3  size/sign op of current beat
load_data_valid  input  1  load data returned this cycle
beat_reg  output  REG_ADDR_BITS  register read (store) or written (load) by current beat
wb_en  output  1  write load data to beat_reg this cycle
busy  output  1  sequence in progress (state != IDLE)
done  output  1  one-cycle pulse after the final beat completes

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; all outputs 0 except start_ready=1.
  - Internal address, register and count registers are cleared.
  - Reset mid-sequence abandons the sequence; no further requests are issued.
- States: IDLE, REQ, WAIT_LOAD, DONE.
- IDLE:
  - start && start_ready captures all start_* inputs and sets remaining = start_count.
  - Next state is REQ; mem_req_valid rises the next cycle (1-cycle latency).
  - start while not IDLE is ignored; no queueing.
- REQ:
  - mem_req_valid=1; mem_req_write, mem_req_addr, mem_req_op and beat_reg are held stable until mem_req_ready.
  - On mem_req_ready with a store:
    - remaining==0: go to DONE.
    - Otherwise: decrement remaining, addr += 4, beat_reg += start_inc_reg, and stay in REQ. Back-to-back beats are allowed: valid stays high.
  - On mem_req_ready with a load: go to WAIT_LOAD.
  - load_data_valid in REQ is ignored; the memory never returns data in the accept cycle.
- WAIT_LOAD:
  - mem_req_valid=0; wb_en = load_data_valid (combinational), and beat_reg is stable during that cycle.
  - On load_data_valid, same advance rule as a store: if remaining==0 go to DONE, else advance and go to REQ.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - start_ready=0 in DONE, so the earliest new start is accepted in the cycle after done.
- Arithmetic:
  - Address increments modulo 2^ADDR_BITS; 0xFFFFFFC wraps to 0x0000000 at ADDR_BITS=28.
  - beat_reg increments modulo 2^REG_ADDR_BITS; x15 wraps to x0. The beat is still issued; x0 writes are discarded by the register file.
  - beat_reg is held when start_inc_reg=0 (memset).
- mem_req_op equals the captured start_mem_op for every beat. The decoder forces 3'b010 for multi-beat ops; the block does not check this.
- Beat count is 1..8; start_count=0 gives a single access with identical timing rules.
- Total cycles from start to done:
  - stores with ready always high: beats+1;
  - loads: sum of request and data waits, plus 1.

Decomposition:
- Shared package tinyqv_pkg:
  - state encoding constants SEQ_IDLE, SEQ_REQ, SEQ_WAIT_LOAD, SEQ_DONE;
  - MEM_OP_WORD = 3'b010;
  - constant ADDR_STRIDE = 4.
- No sub-module; counter, address and register incrementers are inline.

Test Plan:
- Single LW: start_addr=0x100, start_reg=8, count=0, ready high, data 2 cycles after accept -> one request at 0x100 with op 010; wb_en with beat_reg=8; done; 4 cycles to IDLE.
- LW4: addr=0x200, reg=9, count=3, inc=1 -> loads at 0x200/204/208/20C, wb_en with beat_reg 9,10,11,12, one done pulse.
- SCXT 8 regs: count=7, reg=9, store, mem_req_ready toggling 1,0,1 -> 8 writes, each held stable while ready=0; addrs +4 each; regs 9..15 then 0.
- Memset: store, count=3, inc=0, reg=5 -> 4 writes of reg 5 at consecutive addresses; done 5 cycles after start with ready high.
- Wrap: addr=0xFFFFFF8, count=3, ADDR_BITS=28 -> addrs 0xFFFFFF8, 0xFFFFFFC, 0x0000000, 0x0000004.
- Reset and start while busy:
  - start asserted again in REQ -> ignored;
  - rstn low during WAIT_LOAD of beat 2 -> outputs 0 immediately, no wb_en, start_ready=1 after release, next start accepted normally.

Source files
------------

// File: rtl/tinyqv_pkg.sv
// Shared definitions for the TinyQV memory sequencer: FSM states, the
// word-sized memory op code, and the byte stride between consecutive beats.
package tinyqv_pkg;

  // Sequencer states: wait for a start, present a request, wait for load
  // data, and a one-cycle completion marker.
  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_REQ       = 2'd1,
    SEQ_WAIT_LOAD = 2'd2,
    SEQ_DONE      = 2'd3
  } seq_state_e;

  // Size/sign op the decoder uses for every multi-register access.
  localparam logic [2:0] MEM_OP_WORD = 3'b010;

  // Consecutive beats always step by one 32-bit word.
  localparam int unsigned ADDR_STRIDE = 4;

endpackage

// File: rtl/tinyqv_mem_sequencer.sv
// Memory beat sequencer for TinyQV loads and stores.
// One decoded access (single word, 2/4-register, LCXT/SCXT or memset) is
// expanded into 1..8 memory beats. Address, register index and remaining
// beat count advance inline after each completed beat; only one request is
// ever outstanding.
module tinyqv_mem_sequencer
  import tinyqv_pkg::*;
#(
  parameter int REG_ADDR_BITS = 4,
  parameter int ADDR_BITS     = 28
) (
  input  logic                     clk,
  input  logic                     rstn,

  input  logic                     start,
  output logic                     start_ready,
  input  logic                     start_is_store,
  input  logic [ADDR_BITS-1:0]     start_addr,
  input  logic [REG_ADDR_BITS-1:0] start_reg,
  input  logic [2:0]               start_count,
  input  logic                     start_inc_reg,
  input  logic [2:0]               start_mem_op,

  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_write,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic [2:0]               mem_req_op,
  input  logic                     load_data_valid,

  output logic [REG_ADDR_BITS-1:0] beat_reg,
  output logic                     wb_en,
  output logic                     busy,
  output logic                     done
);

  // Sequencing state and captured access description.
  seq_state_e               state_q, state_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic [REG_ADDR_BITS-1:0] reg_q, reg_d;
  logic [2:0]               remaining_q, remaining_d;
  logic                     write_q, write_d;
  logic                     inc_q, inc_d;
  logic [2:0]               op_q, op_d;

  // Registered status outputs, computed from the next state.
  logic                     valid_q;
  logic                     busy_q;
  logic                     done_q;

  // Per-beat advance helpers.
  logic                     last_beat;
  logic [ADDR_BITS-1:0]     addr_next;
  logic [REG_ADDR_BITS-1:0] reg_next;

  assign last_beat = (remaining_q == 3'd0);
  assign addr_next = addr_q + ADDR_BITS'(ADDR_STRIDE);
  assign reg_next  = reg_q + REG_ADDR_BITS'(inc_q);

  // Next-state logic: capture on start, advance after each completed beat.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    reg_d       = reg_q;
    remaining_d = remaining_q;
    write_d     = write_q;
    inc_d       = inc_q;
    op_d        = op_q;

    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d     = SEQ_REQ;
          addr_d      = start_addr;
          reg_d       = start_reg;
          remaining_d = start_count;
          write_d     = start_is_store;
          inc_d       = start_inc_reg;
          op_d        = start_mem_op;
        end
      end

      SEQ_REQ: begin
        if (mem_req_ready) begin
          if (!write_q) begin
            state_d = SEQ_WAIT_LOAD;
          end else if (last_beat) begin
            state_d = SEQ_DONE;
          end else begin
            remaining_d = remaining_q - 3'd1;
            addr_d      = addr_next;
            reg_d       = reg_next;
          end
        end
      end

      SEQ_WAIT_LOAD: begin
        if (load_data_valid) begin
          if (last_beat) begin
            state_d = SEQ_DONE;
          end else begin
            state_d     = SEQ_REQ;
            remaining_d = remaining_q - 3'd1;
            addr_d      = addr_next;
            reg_d       = reg_next;
          end
        end
      end

      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= SEQ_IDLE;
      addr_q      <= '0;
      reg_q       <= '0;
      remaining_q <= '0;
      write_q     <= 1'b0;
      inc_q       <= 1'b0;
      op_q        <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      reg_q       <= reg_d;
      remaining_q <= remaining_d;
      write_q     <= write_d;
      inc_q       <= inc_d;
      op_q        <= op_d;
      valid_q     <= (state_d == SEQ_REQ);
      busy_q      <= (state_d != SEQ_IDLE);
      done_q      <= (state_d == SEQ_DONE);
    end
  end

  // A new access can only be taken once the previous one has fully retired.
  assign start_ready = (state_q == SEQ_IDLE);

  // Load write-back follows the data strobe directly so the register file
  // captures it in the same cycle.
  assign wb_en = (state_q == SEQ_WAIT_LOAD) && load_data_valid;

  assign mem_req_valid = valid_q;
  assign mem_req_write = write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_op    = op_q;
  assign beat_reg      = reg_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_tinyqv_mem_sequencer.sv
// Self-checking bench for tinyqv_mem_sequencer. Expected beats are pushed to
// a scoreboard when a sequence is started and popped as the DUT issues
// requests and write-backs.
module tb_tinyqv_mem_sequencer;
  import tinyqv_pkg::*;

  localparam int RB = 4;
  localparam int AB = 28;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          start_ready;
  logic          start_is_store = 1'b0;
  logic [AB-1:0] start_addr = '0;
  logic [RB-1:0] start_reg = '0;
  logic [2:0]    start_count = '0;
  logic          start_inc_reg = 1'b0;
  logic [2:0]    start_mem_op = '0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_write;
  logic [AB-1:0] mem_req_addr;
  logic [2:0]    mem_req_op;
  logic          load_data_valid = 1'b0;
  logic [RB-1:0] beat_reg;
  logic          wb_en;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic          write;
    logic [AB-1:0] addr;
    logic [2:0]    op;
    logic [RB-1:0] rg;
  } beat_t;

  beat_t         expQ[$];
  logic [RB-1:0] expWb[$];

  int checks = 0;
  int errors = 0;

  tinyqv_mem_sequencer #(
    .REG_ADDR_BITS(RB),
    .ADDR_BITS(AB)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .start_ready(start_ready),
    .start_is_store(start_is_store),
    .start_addr(start_addr),
    .start_reg(start_reg),
    .start_count(start_count),
    .start_inc_reg(start_inc_reg),
    .start_mem_op(start_mem_op),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr),
    .mem_req_op(mem_req_op),
    .load_data_valid(load_data_valid),
    .beat_reg(beat_reg),
    .wb_en(wb_en),
    .busy(busy),
    .done(done)
  );

  // Free-running clock, active edge is posedge.
  always #5 clk = ~clk;

  // Single comparison point with failure accounting.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one sequence: push expected beats, drive start, act as memory, and
  // check every request, write-back and the start-to-done cycle count.
  task automatic applyStimulus(input string name, input logic isStore, input logic [AB-1:0] addr,
                               input logic [RB-1:0] rg, input logic [2:0] cnt, input logic inc,
                               input logic [2:0] op, input bit toggleReady, input int loadLat,
                               input bit pokeBusy, input int expCycles);
    beat_t b;
    beat_t hold;
    bit    prevHold;
    bit    pending;
    bit    phase;
    bit    finished;
    int    dataAt;
    int    cyc;
    $display("[TB] sequence %s", name);
    for (int i = 0; i <= int'(cnt); i++) begin
      b.write = isStore;
      b.addr  = addr + AB'(4 * i);
      b.op    = op;
      b.rg    = rg + (inc ? RB'(i) : RB'(0));
      expQ.push_back(b);
      if (!isStore) expWb.push_back(b.rg);
    end

    @(negedge clk);
    start          = 1'b1;
    start_is_store = isStore;
    start_addr     = addr;
    start_reg      = rg;
    start_count    = cnt;
    start_inc_reg  = inc;
    start_mem_op   = op;
    mem_req_ready  = 1'b0;
    #1;
    checkOutput({name, "_start_ready"}, 64'(start_ready), 64'd1);

    prevHold = 0; pending = 0; phase = 1; finished = 0; dataAt = 0; cyc = 0;
    hold = '0;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 300) begin
      cyc++;
      if (cyc > 1) @(negedge clk);
      mem_req_ready   = toggleReady ? phase : 1'b1;
      phase           = ~phase;
      load_data_valid = pending && (cyc == dataAt);
      if (pokeBusy && cyc == 1) begin
        start          = 1'b1;
        start_is_store = ~isStore;
        start_addr     = 28'h0ABCDE0;
        start_reg      = 4'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      if (prevHold)
        checkOutput({name, "_hold_stable"},
                    64'({mem_req_valid, mem_req_write, mem_req_addr, mem_req_op, beat_reg}),
                    64'({1'b1, hold}));
      prevHold = mem_req_valid && !mem_req_ready;
      hold     = {mem_req_write, mem_req_addr, mem_req_op, beat_reg};
      if (mem_req_valid && mem_req_ready) begin
        if (expQ.size() == 0) begin
          checkOutput({name, "_extra_req"}, 64'(mem_req_addr), 64'hFFFF_FFFF);
        end else begin
          b = expQ.pop_front();
          checkOutput({name, "_req"}, 64'({mem_req_write, mem_req_addr, mem_req_op, beat_reg}), 64'(b));
        end
        if (!isStore) begin
          pending = 1;
          dataAt  = cyc + loadLat;
        end
      end
      checkOutput({name, "_wb_en"}, 64'(wb_en), 64'(load_data_valid));
      if (load_data_valid) begin
        pending = 0;
        if (expWb.size() == 0)
          checkOutput({name, "_extra_wb"}, 64'(beat_reg), 64'hFF);
        else
          checkOutput({name, "_wb_reg"}, 64'(beat_reg), 64'(expWb.pop_front()));
      end
      if (done) begin
        finished = 1;
        checkOutput({name, "_busy_in_done"}, 64'(busy), 64'd1);
        checkOutput({name, "_cycles"}, 64'(cyc), 64'(expCycles));
      end
    end
    checkOutput({name, "_finished"}, 64'(finished), 64'd1);
    checkOutput({name, "_beats_left"}, 64'(expQ.size() + expWb.size()), 64'd0);
    expQ.delete();
    expWb.delete();

    @(negedge clk);
    mem_req_ready   = 1'b0;
    load_data_valid = 1'b0;
    start           = 1'b0;
    #1;
    checkOutput({name, "_idle_after"}, 64'({start_ready, busy, done, mem_req_valid}), 64'b1000);
  endtask

  initial begin
    // Reset state.
    rstn = 1'b0;
    #12;
    checkOutput("reset_outputs",
                64'({start_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_req_op,
                     beat_reg, wb_en, busy, done}),
                64'({1'b1, 1'b0, 1'b0, 28'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    rstn = 1'b1;

    applyStimulus("lw1",    1'b0, 28'h0000100, 4'd8, 3'd0, 1'b1, MEM_OP_WORD, 0, 2, 0, 4);
    applyStimulus("lw4",    1'b0, 28'h0000200, 4'd9, 3'd3, 1'b1, MEM_OP_WORD, 0, 1, 0, 9);
    applyStimulus("scxt8",  1'b1, 28'h0000400, 4'd9, 3'd7, 1'b1, MEM_OP_WORD, 1, 0, 0, 16);
    applyStimulus("memset", 1'b1, 28'h0000500, 4'd5, 3'd3, 1'b0, MEM_OP_WORD, 0, 0, 0, 5);
    applyStimulus("wrap",   1'b1, 28'hFFFFFF8, 4'd1, 3'd3, 1'b1, MEM_OP_WORD, 0, 0, 1, 5);

    // Reset during the data wait of the second load beat.
    $display("[TB] sequence reset_mid");
    @(negedge clk);
    start = 1'b1; start_is_store = 1'b0; start_addr = 28'h0000300; start_reg = 4'd2;
    start_count = 3'd3; start_inc_reg = 1'b1; start_mem_op = MEM_OP_WORD;
    mem_req_ready = 1'b1; load_data_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1 checkOutput("rst_beat1_req", 64'({mem_req_valid, mem_req_addr, beat_reg}), 64'({1'b1, 28'h0000300, 4'd2}));
    @(negedge clk);
    load_data_valid = 1'b1;
    #1 checkOutput("rst_beat1_wb", 64'({wb_en, beat_reg}), 64'({1'b1, 4'd2}));
    @(negedge clk);
    load_data_valid = 1'b0;
    #1 checkOutput("rst_beat2_req", 64'({mem_req_valid, mem_req_addr, beat_reg}), 64'({1'b1, 28'h0000304, 4'd3}));
    @(negedge clk);
    #1 checkOutput("rst_beat2_wait", 64'({busy, mem_req_valid}), 64'b10);
    rstn = 1'b0;
    load_data_valid = 1'b1;
    #1;
    checkOutput("rst_mid_outputs",
                64'({start_ready, mem_req_valid, mem_req_addr, beat_reg, wb_en, busy, done}),
                64'({1'b1, 1'b0, 28'h0, 4'h0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    load_data_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 checkOutput("rst_quiet", 64'({start_ready, mem_req_valid, busy}), 64'b100);
    end

    applyStimulus("sh_after_rst", 1'b1, 28'h0000040, 4'd1, 3'd0, 1'b1, 3'b001, 0, 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute watchdog so the run always ends with a summary line.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
